centroid_calc: RTL and testbench

CENTROID_CALC -- requirements
Module: centroid_calc

---
 rtl/centroid_calc.sv | 192 +++++++++++++++++++
 tb/tb_centroid_calc.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_calc.sv
// Binary-mask centroid: accumulates image moments per frame, then divides
// sequentially (restoring shift-subtract) to publish the object centroid.
module centroid_calc #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        mask_in,
  output logic [10:0] x_center,
  output logic [10:0] y_center,
  output logic        valid,
  output logic        obj_det,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DIV_X = 2'd1;
  localparam logic [1:0] DIV_Y = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [10:0] x_pos, y_pos;
  logic        prev_vsync;
  logic [19:0] m00;
  logic [31:0] m10, m01;
  logic [19:0] div_m00;
  logic [31:0] div_m10, div_m01;
  logic [1:0]  state, state_next;
  logic [5:0]  cnt;
  logic [31:0] rem, quo, rem_next, quo_next;
  logic [32:0] rem_shift;
  logic        div_ge;
  logic [10:0] quo_x;
  logic        empty;
  logic        frame_end, pix_act;
  logic        unused_hsync;

  assign unused_hsync = h_sync_in;
  assign frame_end    = v_sync_in & ~prev_vsync;
  assign pix_act      = de_in & ~v_sync_in;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem, quo[31]};
    div_ge    = (rem_shift >= {13'd0, div_m00});
    if (div_ge) begin
      rem_next = 32'(rem_shift - {13'd0, div_m00});
    end else begin
      rem_next = rem_shift[31:0];
    end
    quo_next = {quo[30:0], div_ge};
  end

  // Sequencer: setup cycle + 32 steps for x, 32 steps for y, then one publish cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (frame_end) begin
          state_next = (m00 != 20'd0) ? DIV_X : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      DIV_X: begin
        if (cnt == 6'd32) begin
          state_next = DIV_Y;
        end else begin
          state_next = DIV_X;
        end
      end
      DIV_Y: begin
        if (cnt == 6'd31) begin
          state_next = DONE;
        end else begin
          state_next = DIV_Y;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pixel position counters, aligned with the downstream crosshair stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos      <= 11'd0;
      y_pos      <= 11'd0;
      prev_vsync <= 1'b0;
    end else begin
      prev_vsync <= v_sync_in;
      if (v_sync_in) begin
        x_pos <= 11'd0;
        y_pos <= 11'd0;
      end else if (de_in) begin
        if (x_pos == 11'(IMG_W - 1)) begin
          x_pos <= 11'd0;
          y_pos <= (y_pos == 11'(IMG_H - 1)) ? 11'd0 : y_pos + 11'd1;
        end else begin
          x_pos <= x_pos + 11'd1;
        end
      end
    end
  end

  // Moment accumulators; snapshot only when the divider is free, always clear at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m00     <= 20'd0;
      m10     <= 32'd0;
      m01     <= 32'd0;
      div_m00 <= 20'd0;
      div_m10 <= 32'd0;
      div_m01 <= 32'd0;
      empty   <= 1'b0;
    end else begin
      if (frame_end) begin
        m00 <= 20'd0;
        m10 <= 32'd0;
        m01 <= 32'd0;
        if (state == IDLE) begin
          div_m00 <= m00;
          div_m10 <= m10;
          div_m01 <= m01;
          empty   <= (m00 == 20'd0);
        end
      end else if (pix_act && mask_in) begin
        m00 <= m00 + 20'd1;
        m10 <= m10 + {21'd0, x_pos};
        m01 <= m01 + {21'd0, y_pos};
      end
    end
  end

  // Divider datapath and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      quo_x    <= 11'd0;
      x_center <= 11'd0;
      y_center <= 11'd0;
      obj_det  <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      valid <= (state == DONE);
      case (state)
        DIV_X: begin
          if (cnt == 6'd0) begin
            rem <= 32'd0;
            quo <= div_m10;
            cnt <= 6'd1;
          end else if (cnt == 6'd32) begin
            quo_x <= quo_next[10:0];
            rem   <= 32'd0;
            quo   <= div_m01;
            cnt   <= 6'd0;
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 6'd1;
          end
        end
        DIV_Y: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 6'd1;
        end
        DONE: begin
          obj_det <= ~empty;
          if (!empty) begin
            x_center <= quo_x;
            y_center <= quo[10:0];
          end
          cnt <= 6'd0;
        end
        default: begin
          cnt <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_calc.sv
// Bench for centroid_calc: directed scenarios plus random masks, checked every
// cycle against a frame-level moment/latency model.
module tb_centroid_calc;
  localparam int W = 64;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        rst, de_in, h_sync_in, v_sync_in, mask_in;
  logic [10:0] x_center, y_center;
  logic        valid, obj_det, busy;

  always #5 clk = ~clk;

  centroid_calc #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in),
    .v_sync_in(v_sync_in), .mask_in(mask_in), .x_center(x_center),
    .y_center(y_center), .valid(valid), .obj_det(obj_det), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  bit mp [0:H-1][0:W-1];
  longint fm00 = 0, fm10 = 0, fm01 = 0;

  int cyc = 0, due = 0, fe_cyc = 0;
  bit pend = 0, m_prev = 0, r_empty = 0;
  longint r_x = 0, r_y = 0;
  logic [10:0] ex = 11'd0, ey = 11'd0;
  bit eobj = 0, evalid = 0, ebusy = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame-level reference: a frame result is accepted only when no result is pending.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      evalid = 0;
      if (rst) begin
        pend = 0; m_prev = 0; ex = 11'd0; ey = 11'd0; eobj = 0;
      end else begin
        if (v_sync_in && !m_prev) begin
          fe_cyc = cyc;
          if (!pend) begin
            pend    = 1;
            r_empty = (fm00 == 0);
            due     = cyc + (r_empty ? 1 : 66);
            if (!r_empty) begin
              r_x = fm10 / fm00;
              r_y = fm01 / fm00;
            end
          end
        end
        if (pend && cyc == due) begin
          evalid = 1;
          pend   = 0;
          eobj   = !r_empty;
          if (!r_empty) begin
            ex = r_x[10:0];
            ey = r_y[10:0];
          end
        end
        m_prev = v_sync_in;
      end
      ebusy = pend;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      chk("valid", valid, evalid);
      chk("busy", busy, ebusy);
      chk("x_center", x_center, ex);
      chk("y_center", y_center, ey);
      chk("obj_det", obj_det, eobj);
    end
  end

  task automatic clear_map();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mp[y][x] = 0;
  endtask

  task automatic set_single(input int px, input int py);
    clear_map();
    mp[py][px] = 1;
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
    clear_map();
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        mp[y][x] = 1;
  endtask

  task automatic set_random(input int den);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        mp[y][x] = ($urandom_range(0, den - 1) == 0);
  endtask

  // Drives one full frame from mp, then raises v_sync (left high on return).
  task automatic drive_frame(input bit rnd);
    longint a0 = 0, a1 = 0, a2 = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (rnd && $urandom_range(0, 15) == 0) begin
          @(negedge clk); de_in = 0; mask_in = 1'($urandom);
        end
        @(negedge clk); de_in = 1; h_sync_in = 0; mask_in = mp[y][x];
        if (mp[y][x]) begin a0++; a1 += x; a2 += y; end
      end
      @(negedge clk); de_in = 0; mask_in = 0; h_sync_in = 1;
    end
    @(negedge clk);
    h_sync_in = 0;
    fm00 = a0; fm10 = a1; fm01 = a2;
    v_sync_in = 1;
  endtask

  task automatic drive_partial(input int n);
    longint a1 = 0;
    @(negedge clk); v_sync_in = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); de_in = 1; mask_in = 1; a1 += i;
    end
    @(negedge clk);
    de_in = 0; mask_in = 0;
    fm00 = n; fm10 = a1; fm01 = 0;
    v_sync_in = 1;
  endtask

  task automatic wait_valid(input string nm, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #3;
      if (valid) begin at = cyc; break; end
    end
    total++;
    if (at < 0) begin
      bad++;
      $display("FAIL %s: no valid pulse within 200 cycles", nm);
    end
  endtask

  task automatic vs_low();
    @(negedge clk); v_sync_in = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    rst = 1; de_in = 0; h_sync_in = 0; v_sync_in = 0; mask_in = 0;
    repeat (3) @(negedge clk);
    chk("rst_x", x_center, 0); chk("rst_y", y_center, 0);
    chk("rst_valid", valid, 0); chk("rst_obj", obj_det, 0); chk("rst_busy", busy, 0);
    rst = 0;

    set_single(10, 20); drive_frame(0);
    wait_valid("single", at);
    chk("single_latency", at - fe_cyc, 66);
    chk("single_x", x_center, 10); chk("single_y", y_center, 20); chk("single_obj", obj_det, 1);
    vs_low();

    set_rect(4, 7, 2, 3); drive_frame(0);
    chk("rect_m00", fm00, 8); chk("rect_m10", fm10, 44); chk("rect_m01", fm01, 20);
    wait_valid("rect", at);
    chk("rect_x", x_center, 5); chk("rect_y", y_center, 2);
    vs_low();

    set_rect(0, W - 1, 0, H - 1); drive_frame(0);
    chk("full_m00", fm00, 4096); chk("full_m10", fm10, 129024);
    wait_valid("full", at);
    chk("full_x", x_center, 31); chk("full_y", y_center, 31);
    vs_low();

    set_single(10, 20); drive_frame(0);
    wait_valid("pre_empty", at); vs_low();
    clear_map(); drive_frame(0);
    wait_valid("empty", at);
    chk("empty_latency", at - fe_cyc, 1);
    chk("empty_obj", obj_det, 0); chk("empty_x", x_center, 10); chk("empty_y", y_center, 20);
    vs_low();

    set_single(20, 30); drive_frame(0);
    repeat (3) @(negedge clk);
    drive_partial(5);
    wait_valid("overlap_first", at);
    chk("overlap_x", x_center, 20); chk("overlap_y", y_center, 30);
    vs_low();
    set_rect(4, 7, 2, 3); drive_frame(0);
    wait_valid("after_overlap", at);
    chk("after_overlap_x", x_center, 5); chk("after_overlap_y", y_center, 2);
    chk("after_overlap_obj", obj_det, 1);
    vs_low();

    set_single(30, 40); drive_frame(0);
    @(posedge clk);
    repeat (53) @(posedge clk);
    @(negedge clk); rst = 1; v_sync_in = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("abort_x", x_center, 0); chk("abort_y", y_center, 0);
    chk("abort_obj", obj_det, 0); chk("abort_busy", busy, 0); chk("abort_valid", valid, 0);
    repeat (80) @(negedge clk);
    set_single(3, 5); drive_frame(0);
    wait_valid("post_reset", at);
    chk("post_reset_x", x_center, 3); chk("post_reset_y", y_center, 5);
    vs_low();

    for (int f = 0; f < 3; f++) begin
      set_random($urandom_range(1, 8));
      drive_frame(1);
      wait_valid("random", at);
      vs_low();
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
